// File: rtl/fa8_seq_adder_ctrl.sv
// rtl/fa8_seq_adder_ctrl.sv - byte-serial FA_8 add/subtract sequencer (subtract enabled by FA8_SEQ_SUB_EN)

// One 8-bit full adder slice.
module fa_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

module fa8_seq_adder_ctrl #(
  parameter int NUM_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     op,
  input  logic [8*NUM_BYTES-1:0]   a,
  input  logic [8*NUM_BYTES-1:0]   b,
  output logic                     busy,
  output logic                     done,
  output logic [8*NUM_BYTES-1:0]   sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int W  = 8 * NUM_BYTES;
  localparam int CW = $clog2(NUM_BYTES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    opa;
  logic [W-1:0]    opb;
  logic [W-1:0]    work;
  logic [W-1:0]    work_nxt;
  logic [W-1:0]    b_eff;
  logic            cin0;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic            last;
  logic [7:0]      fa_s;
  logic            fa_cout;
  logic            ovf_nxt;

`ifdef FA8_SEQ_SUB_EN
  // Subtract is a + ~b + 1: invert b and seed the carry chain with 1.
  assign b_eff = op ? ~b : b;
  assign cin0  = op;
`else
  // Add-only build: op is accepted but has no effect.
  logic unused_op;
  assign unused_op = op;
  assign b_eff     = b;
  assign cin0      = 1'b0;
`endif

  fa_8 u_fa_8 (
    .a    (opa[7:0]),
    .b    (opb[7:0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last = (cnt == LAST_CNT);

  // On the top byte the adder sees the MSBs of a and b_eff directly.
  assign ovf_nxt = (opa[7] == opb[7]) && (fa_s[7] != opa[7]);

  // Merge the current adder byte into the working result at the counter slot.
  always_comb begin
    work_nxt = work;
    work_nxt[int'(cnt) * 8 +: 8] = fa_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, byte-serial accumulation and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b_eff;
            carry <= cin0;
            cnt   <= '0;
          end
        end
        RUN: begin
          work  <= work_nxt;
          carry <= fa_cout;
          opa   <= opa >> 8;
          opb   <= opb >> 8;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum  <= work_nxt;
            cout <= fa_cout;
            ovf  <= ovf_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa8_seq_adder_ctrl.sv
// tb/tb_fa8_seq_adder_ctrl.sv - self-checking bench for fa8_seq_adder_ctrl

module tb_fa8_seq_adder_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;
`ifdef FA8_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int prev_done_cyc = 0;
  bit b2b = 1'b0;
  logic [W-1:0] last_exp_sum = '0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } vec_t;

  vec_t vecs[6];

  fa8_seq_adder_ctrl #(.NUM_BYTES(NB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mop,
                                output logic [W-1:0] ms, output logic mc, output logic mv);
    bit sub;
    longint unsigned u;
    longint sa, sb, r, maxv, minv;
    sub  = mop && SUB_EN;
    sa   = longint'($signed(ma));
    sb   = longint'($signed(mb));
    maxv = (longint'(1) <<< (W - 1)) - 1;
    minv = -(longint'(1) <<< (W - 1));
    if (sub) begin
      ms = ma - mb;
      mc = (ma >= mb);
      r  = sa - sb;
    end else begin
      u  = longint'(ma) + longint'(mb);
      ms = u[W-1:0];
      mc = u[W];
      r  = sa + sb;
    end
    mv = (r > maxv) || (r < minv);
  endfunction

  // Caller must be at a negedge with the DUT idle; returns at the negedge after done.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic top,
                       input logic [W-1:0] es, input logic ec, input logic ev, input string tag);
    int lat;
    bit stable;
    bit busy_ok;
    a = ta; b = tb2; op = top; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
    lat = 1; stable = 1'b1; busy_ok = 1'b1;
    while (!done && lat < 3 * NB) begin
      if (!busy) busy_ok = 1'b0;
      if (sum !== last_exp_sum) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(NB + 1));
    check({tag, " busy while running"}, 64'(busy_ok), 64'd1);
    check({tag, " busy low at done"}, 64'(busy), 64'd0);
    check({tag, " sum stable before done"}, 64'(stable), 64'd1);
    check({tag, " sum"}, 64'(sum), 64'(es));
    check({tag, " cout"}, 64'(cout), 64'(ec));
    check({tag, " ovf"}, 64'(ovf), 64'(ev));
    if (b2b) check({tag, " done spacing"}, 64'(cyc - prev_done_cyc), 64'(NB + 2));
    prev_done_cyc = cyc;
    last_exp_sum  = es;
    @(negedge clk);
    check({tag, " done one cycle"}, 64'(done), 64'd0);
    b2b = 1'b1;
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int done_idx;
    logic [W-1:0] rs, ra, rb;
    logic rc, rv, rop;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
`ifdef FA8_SEQ_SUB_EN
    vecs[4] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
`else
    vecs[4] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'h0000_000C, 1'b0, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0001, 1'b0, 1'b0};
`endif

    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset cout", 64'(cout), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].s, vecs[i].c, vecs[i].v, $sformatf("vec%0d", i));
    end

    // Start pulsed again mid-run must be ignored.
    b2b = 1'b0;
    a = 32'h1234_5678; b = 32'h0101_0101; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 32'h1111_1111; b = 32'h2222_2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; done_idx = -1;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        ndone++;
        if (done_idx < 0) done_idx = i;
      end
      @(negedge clk);
    end
    check("ignored start done count", 64'(ndone), 64'd1);
    check("ignored start done cycle", 64'(done_idx), 64'd2);
    check("ignored start sum", 64'(sum), 64'h1335_5779);
    check("ignored start cout", 64'(cout), 64'd0);
    last_exp_sum = 32'h1335_5779;

    // Reset in the middle of a run aborts it.
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst sum", 64'(sum), 64'd0);
    check("midrst cout", 64'(cout), 64'd0);
    check("midrst ovf", 64'(ovf), 64'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("midrst no done", 64'(ndone), 64'd0);
    last_exp_sum = '0;
    b2b = 1'b0;
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "after reset");

    // Back-to-back random operations against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0: ra = 32'hFFFF_FFFF;
        1: ra = 32'h8000_0000;
        2: ra = 32'h7FFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'h0000_0001;
        1: rb = 32'h8000_0000;
        2: rb = 32'h0000_0000;
        default: rb = $urandom;
      endcase
      rop = 1'($urandom_range(0, 1));
      model(ra, rb, rop, rs, rc, rv);
      do_op(ra, rb, rop, rs, rc, rv, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
